// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - request, array and bus-bridge signal bundle for the L1 cache control FSM
interface cache_ctrl_if #(
    parameter int WAYS       = 4,
    parameter int LINE_BEATS = 16
);
    localparam int BW = $clog2(LINE_BEATS);

    // Pipeline request, tag compare results and bus-bridge handshakes into the FSM
    logic            valid;
    logic            op;
    logic            cache_hit;
    logic [WAYS-1:0] hit;
    logic [WAYS-1:0] lru_way;
    logic            victim_dirty;
    logic            r_rdy;
    logic            r_valid;
    logic            w_rdy;
    logic            b_done;

    // Array, buffer and bus-bridge controls from the FSM
    logic            rbuf_we;
    logic            mbuf_we;
    logic            rdata_sel;
    logic            way_sel_en;
    logic            data_valid;
    logic            r_req;
    logic            r_data_ready;
    logic            w_req;
    logic [WAYS-1:0] way_visit;
    logic [WAYS-1:0] mem_we;
    logic [WAYS-1:0] tagv_we;
    logic [WAYS-1:0] dirty_set;
    logic [WAYS-1:0] dirty_clr;
    logic [BW-1:0]   fill_beat;
    logic            stall;

    // Surrounding logic: drives requests and handshakes, consumes controls
    modport master (
        output valid, op, cache_hit, hit, lru_way, victim_dirty,
               r_rdy, r_valid, w_rdy, b_done,
        input  rbuf_we, mbuf_we, rdata_sel, way_sel_en, data_valid,
               r_req, r_data_ready, w_req, way_visit, mem_we, tagv_we,
               dirty_set, dirty_clr, fill_beat, stall
    );

    // Control FSM side
    modport slave (
        input  valid, op, cache_hit, hit, lru_way, victim_dirty,
               r_rdy, r_valid, w_rdy, b_done,
        output rbuf_we, mbuf_we, rdata_sel, way_sel_en, data_valid,
               r_req, r_data_ready, w_req, way_visit, mem_we, tagv_we,
               dirty_set, dirty_clr, fill_beat, stall
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - L1 cache main control FSM: lookup, dirty writeback, line refill
module cache_ctrl_fsm #(
    parameter int WAYS       = 4,
    parameter int LINE_BEATS = 16,
    parameter int WB_EN      = 1
) (
    input  logic         clk,
    input  logic         rstn,
    cache_ctrl_if.slave  bus
);
    localparam int   BW       = $clog2(LINE_BEATS);
    localparam logic WB       = (WB_EN != 0);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WB_REQ  = 3'd2,
        S_WB_RESP = 3'd3,
        S_REPLACE = 3'd4,
        S_REFILL  = 3'd5
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_fill_beat;

    // Store and dirty-victim qualifiers collapse to 0 in the read-only (I-cache) build
    logic w_store;
    logic w_wb_victim;
    logic w_last_beat;

    assign w_store     = WB & bus.op;
    assign w_wb_victim = WB & bus.victim_dirty;
    assign w_last_beat = (r_state == S_REFILL) && bus.r_valid && (r_fill_beat == LAST_BEAT);

    // State and refill beat counter; beat counter wraps naturally since LINE_BEATS is a power of 2
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_fill_beat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) r_state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (bus.cache_hit)
                        r_state <= bus.valid ? S_LOOKUP : S_IDLE;
                    else if (w_wb_victim)
                        r_state <= S_WB_REQ;
                    else
                        r_state <= S_REPLACE;
                end
                S_WB_REQ: begin
                    if (bus.w_rdy) r_state <= S_WB_RESP;
                end
                S_WB_RESP: begin
                    if (bus.b_done) r_state <= S_REPLACE;
                end
                S_REPLACE: begin
                    if (bus.r_rdy) begin
                        r_state     <= S_REFILL;
                        r_fill_beat <= '0;
                    end
                end
                S_REFILL: begin
                    if (bus.r_valid) begin
                        r_fill_beat <= r_fill_beat + BW'(1);
                        if (r_fill_beat == LAST_BEAT)
                            r_state <= bus.valid ? S_LOOKUP : S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_fill_beat <= '0;
                end
            endcase
        end
    end

    logic            w_rbuf_we;
    logic            w_mbuf_we;
    logic            w_rdata_sel;
    logic            w_way_sel_en;
    logic            w_data_valid;
    logic            w_r_req;
    logic            w_r_data_ready;
    logic            w_w_req;
    logic            w_stall;
    logic [WAYS-1:0] w_way_visit;
    logic [WAYS-1:0] w_mem_we;
    logic [WAYS-1:0] w_tagv_we;
    logic [WAYS-1:0] w_dirty_set;
    logic [WAYS-1:0] w_dirty_clr;

    // Output decode from state and inputs; while rstn is low only the IDLE decode is driven
    always_comb begin
        w_rbuf_we      = 1'b0;
        w_mbuf_we      = 1'b0;
        w_rdata_sel    = 1'b0;
        w_way_sel_en   = 1'b0;
        w_data_valid   = 1'b0;
        w_r_req        = 1'b0;
        w_r_data_ready = 1'b0;
        w_w_req        = 1'b0;
        w_stall        = 1'b0;
        w_way_visit    = '0;
        w_mem_we       = '0;
        w_tagv_we      = '0;
        w_dirty_set    = '0;
        w_dirty_clr    = '0;
        if (!rstn) begin
            w_rbuf_we = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_rbuf_we = 1'b1;
                end
                S_LOOKUP: begin
                    w_rdata_sel = 1'b1;
                    if (bus.cache_hit) begin
                        w_way_visit  = bus.hit;
                        w_way_sel_en = 1'b1;
                        w_rbuf_we    = 1'b1;
                        w_data_valid = 1'b1;
                        if (w_store) begin
                            w_mem_we    = bus.hit;
                            w_dirty_set = bus.hit;
                        end
                    end else begin
                        w_mbuf_we = 1'b1;
                        w_stall   = 1'b1;
                    end
                end
                S_WB_REQ: begin
                    w_w_req = WB;
                    w_stall = 1'b1;
                end
                S_WB_RESP: begin
                    w_stall = 1'b1;
                end
                S_REPLACE: begin
                    w_r_req = 1'b1;
                    w_stall = 1'b1;
                end
                S_REFILL: begin
                    w_r_data_ready = 1'b1;
                    w_stall        = 1'b1;
                    if (bus.r_valid)
                        w_mem_we = bus.lru_way;
                    if (w_last_beat) begin
                        w_tagv_we    = bus.lru_way;
                        w_way_visit  = bus.lru_way;
                        w_way_sel_en = 1'b1;
                        w_data_valid = 1'b1;
                        w_rbuf_we    = 1'b1;
                        w_stall      = 1'b0;
                        // The datapath merges a pending store into this last-beat write
                        if (w_store)
                            w_dirty_set = bus.lru_way;
                        else if (WB)
                            w_dirty_clr = bus.lru_way;
                    end
                end
                default: begin
                    w_rbuf_we = 1'b1;
                end
            endcase
        end
    end

    assign bus.rbuf_we      = w_rbuf_we;
    assign bus.mbuf_we      = w_mbuf_we;
    assign bus.rdata_sel    = w_rdata_sel;
    assign bus.way_sel_en   = w_way_sel_en;
    assign bus.data_valid   = w_data_valid;
    assign bus.r_req        = w_r_req;
    assign bus.r_data_ready = w_r_data_ready;
    assign bus.w_req        = w_w_req;
    assign bus.stall        = w_stall;
    assign bus.way_visit    = w_way_visit;
    assign bus.mem_we       = w_mem_we;
    assign bus.tagv_we      = w_tagv_we;
    assign bus.dirty_set    = w_dirty_set;
    assign bus.dirty_clr    = w_dirty_clr;
    assign bus.fill_beat    = rstn ? r_fill_beat : '0;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - bench for cache_ctrl_fsm, write-back and read-only builds side by side
module tb_cache_ctrl_fsm;
    localparam int WAYS = 4;
    localparam int LB   = 16;

    localparam int P_IDLE = 0, P_LOOK = 1, P_WBREQ = 2, P_WBRESP = 3, P_REPL = 4, P_FILL = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       t_valid, t_op, t_cache_hit, t_victim_dirty;
    logic       t_r_rdy, t_r_valid, t_w_rdy, t_b_done;
    logic [3:0] t_hit, t_lru;

    cache_ctrl_if #(.WAYS(WAYS), .LINE_BEATS(LB)) if_wb ();
    cache_ctrl_if #(.WAYS(WAYS), .LINE_BEATS(LB)) if_ro ();

    assign if_wb.valid = t_valid;        assign if_ro.valid = t_valid;
    assign if_wb.op = t_op;              assign if_ro.op = t_op;
    assign if_wb.cache_hit = t_cache_hit; assign if_ro.cache_hit = t_cache_hit;
    assign if_wb.hit = t_hit;            assign if_ro.hit = t_hit;
    assign if_wb.lru_way = t_lru;        assign if_ro.lru_way = t_lru;
    assign if_wb.victim_dirty = t_victim_dirty; assign if_ro.victim_dirty = t_victim_dirty;
    assign if_wb.r_rdy = t_r_rdy;        assign if_ro.r_rdy = t_r_rdy;
    assign if_wb.r_valid = t_r_valid;    assign if_ro.r_valid = t_r_valid;
    assign if_wb.w_rdy = t_w_rdy;        assign if_ro.w_rdy = t_w_rdy;
    assign if_wb.b_done = t_b_done;      assign if_ro.b_done = t_b_done;

    cache_ctrl_fsm #(.WAYS(WAYS), .LINE_BEATS(LB), .WB_EN(1)) u_wb (
        .clk(clk), .rstn(rstn), .bus(if_wb.slave));
    cache_ctrl_fsm #(.WAYS(WAYS), .LINE_BEATS(LB), .WB_EN(0)) u_ro (
        .clk(clk), .rstn(rstn), .bus(if_ro.slave));

    // {rbuf_we,mbuf_we,rdata_sel,way_sel_en,data_valid,r_req,r_data_ready,w_req,stall,
    //  way_visit,mem_we,tagv_we,dirty_set,dirty_clr,fill_beat}
    wire [32:0] act_wb = {if_wb.rbuf_we, if_wb.mbuf_we, if_wb.rdata_sel, if_wb.way_sel_en,
                          if_wb.data_valid, if_wb.r_req, if_wb.r_data_ready, if_wb.w_req,
                          if_wb.stall, if_wb.way_visit, if_wb.mem_we, if_wb.tagv_we,
                          if_wb.dirty_set, if_wb.dirty_clr, if_wb.fill_beat};
    wire [32:0] act_ro = {if_ro.rbuf_we, if_ro.mbuf_we, if_ro.rdata_sel, if_ro.way_sel_en,
                          if_ro.data_valid, if_ro.r_req, if_ro.r_data_ready, if_ro.w_req,
                          if_ro.stall, if_ro.way_visit, if_ro.mem_we, if_ro.tagv_we,
                          if_ro.dirty_set, if_ro.dirty_clr, if_ro.fill_beat};

    int errors = 0;
    int checks = 0;
    int m_ph[2];
    int m_bt[2];

    // Expected control bundle for one build, from the request's current phase and beat count
    function automatic logic [32:0] expect_out(bit wb, int ph, int beat);
        logic rbuf = 0, mbuf = 0, rsel = 0, wsel = 0, dv = 0, rreq = 0, rdr = 0, wreq = 0, stl = 0;
        logic [3:0] visit = 0, mwe = 0, twe = 0, dset = 0, dclr = 0;
        bit st = wb && t_op;
        if (!rstn) return {1'b1, 32'd0};
        if (ph == P_IDLE) rbuf = 1;
        else if (ph == P_LOOK) begin
            rsel = 1;
            if (t_cache_hit) begin
                visit = t_hit; wsel = 1; rbuf = 1; dv = 1;
                if (st) begin mwe = t_hit; dset = t_hit; end
            end else begin
                mbuf = 1; stl = 1;
            end
        end else if (ph == P_WBREQ) begin wreq = 1; stl = 1; end
        else if (ph == P_WBRESP) stl = 1;
        else if (ph == P_REPL) begin rreq = 1; stl = 1; end
        else begin
            rdr = 1; stl = 1;
            if (t_r_valid) mwe = t_lru;
            if (t_r_valid && beat == LB - 1) begin
                twe = t_lru; visit = t_lru; wsel = 1; dv = 1; rbuf = 1; stl = 0;
                if (st) dset = t_lru;
                else if (wb) dclr = t_lru;
            end
        end
        return {rbuf, mbuf, rsel, wsel, dv, rreq, rdr, wreq, stl, visit, mwe, twe, dset, dclr,
                4'(beat)};
    endfunction

    // Advance one build's request phase at the clock edge
    task automatic advance(int k, bit wb);
        int ph = m_ph[k];
        int bt = m_bt[k];
        if (!rstn) begin ph = P_IDLE; bt = 0; end
        else case (ph)
            P_IDLE:   if (t_valid) ph = P_LOOK;
            P_LOOK:   if (t_cache_hit) ph = t_valid ? P_LOOK : P_IDLE;
                      else ph = (wb && t_victim_dirty) ? P_WBREQ : P_REPL;
            P_WBREQ:  if (t_w_rdy) ph = P_WBRESP;
            P_WBRESP: if (t_b_done) ph = P_REPL;
            P_REPL:   if (t_r_rdy) begin ph = P_FILL; bt = 0; end
            default:  if (t_r_valid) begin
                          if (bt == LB - 1) begin bt = 0; ph = t_valid ? P_LOOK : P_IDLE; end
                          else bt = bt + 1;
                      end
        endcase
        m_ph[k] = ph;
        m_bt[k] = bt;
    endtask

    // One clock: compare both builds away from the edge, then update the model at the edge
    task automatic step(string tag);
        logic [32:0] e_wb, e_ro;
        @(negedge clk);
        e_wb = expect_out(1'b1, m_ph[0], m_bt[0]);
        e_ro = expect_out(1'b0, m_ph[1], m_bt[1]);
        checks++;
        assert (act_wb === e_wb) else begin
            errors++;
            $error("FAIL %s wb_build got=%h want=%h", tag, act_wb, e_wb);
        end
        checks++;
        assert (act_ro === e_ro) else begin
            errors++;
            $error("FAIL %s ro_build got=%h want=%h", tag, act_ro, e_ro);
        end
        @(posedge clk);
        advance(0, 1'b1);
        advance(1, 1'b0);
        #1;
    endtask

    task automatic quiet();
        t_valid = 0; t_op = 0; t_cache_hit = 0; t_victim_dirty = 0;
        t_r_rdy = 0; t_r_valid = 0; t_w_rdy = 0; t_b_done = 0;
        t_hit = 4'b0001; t_lru = 4'b0001;
    endtask

    initial begin
        m_ph[0] = P_IDLE; m_ph[1] = P_IDLE; m_bt[0] = 0; m_bt[1] = 0;
        quiet();
        rstn = 0;
        #1;
        step("reset0");
        step("reset1");
        checks++;
        assert (act_wb === {1'b1, 32'd0}) else begin
            errors++;
            $error("FAIL reset_idle got=%h want=%h", act_wb, {1'b1, 32'd0});
        end
        rstn = 1;
        step("idle");

        // 1: back-to-back load hits on way 1
        t_valid = 1; t_cache_hit = 1; t_hit = 4'b0010;
        step("t1_idle"); step("t1_hit0"); step("t1_hit1");
        t_valid = 0; step("t1_hit_last"); step("t1_idle_after");

        // 2: clean load miss, slow address accept, refill beats with gaps
        t_valid = 1; t_cache_hit = 0; t_lru = 4'b0100; t_victim_dirty = 0; t_op = 0;
        step("t2_idle"); step("t2_lookup");
        for (int i = 0; i < 3; i++) step("t2_replace_wait");
        t_r_rdy = 1; step("t2_replace_acc"); t_r_rdy = 0;
        for (int b = 0; b < LB; b++) begin
            t_r_valid = 1; step($sformatf("t2_beat%0d", b));
            if (b != LB - 1) begin t_r_valid = 0; step("t2_gap"); end
        end
        t_r_valid = 0; t_cache_hit = 1; t_hit = 4'b0100;
        step("t2_replay"); t_valid = 0; step("t2_replay_done"); step("t2_idle_end");

        // 3 and 6: dirty store miss; b_done in WB_REQ and r_valid in REPLACE are ignored
        t_valid = 1; t_op = 1; t_cache_hit = 0; t_victim_dirty = 1; t_lru = 4'b1000;
        step("t3_idle"); step("t3_lookup");
        t_b_done = 1; step("t3_wbreq_bdone"); step("t3_wbreq_bdone2");
        t_b_done = 0; t_w_rdy = 1; step("t3_wbreq_acc"); t_w_rdy = 0;
        step("t3_wbresp_wait"); step("t3_wbresp_wait2");
        t_b_done = 1; step("t3_wbresp_done"); t_b_done = 0;
        t_r_valid = 1; step("t3_replace_rvalid"); step("t3_replace_rvalid2");
        t_r_valid = 0; t_r_rdy = 1; step("t3_replace_acc"); t_r_rdy = 0;
        for (int b = 0; b < LB + 4; b++) begin
            t_r_valid = 1; step($sformatf("t3_beat%0d", b));
        end
        t_r_valid = 0; t_valid = 0; quiet();
        for (int i = 0; i < 4; i++) step("t3_drain");

        // 4: store hit on way 3
        t_valid = 1; t_op = 1; t_cache_hit = 1; t_hit = 4'b1000;
        step("t4_idle"); step("t4_store_hit");
        checks++;
        assert (if_ro.mem_we === 4'b0000 && if_ro.dirty_set === 4'b0000) else begin
            errors++;
            $error("FAIL t4_ro_store got=%b/%b want=0000/0000", if_ro.mem_we, if_ro.dirty_set);
        end
        t_valid = 0; step("t4_store_hit2"); step("t4_idle_end");

        // 5: reset during refill beat 7, next miss restarts at beat 0
        quiet(); t_valid = 1; t_lru = 4'b0001;
        step("t5_idle"); step("t5_lookup"); t_r_rdy = 1; step("t5_replace"); t_r_rdy = 0;
        t_r_valid = 1;
        for (int b = 0; b < 7; b++) step($sformatf("t5_beat%0d", b));
        rstn = 0; step("t5_reset_beat7");
        rstn = 1; t_r_valid = 0; t_valid = 0;
        checks++;
        assert (if_wb.fill_beat === 4'd0) else begin
            errors++;
            $error("FAIL t5_beat_cleared got=%0d want=0", if_wb.fill_beat);
        end
        step("t5_idle_after");
        t_valid = 1; step("t5_idle2"); step("t5_lookup2");
        t_r_rdy = 1; step("t5_replace2"); t_r_rdy = 0;
        t_r_valid = 1; step("t5_restart_beat0"); step("t5_restart_beat1");
        quiet(); rstn = 0; step("t5_reset2"); rstn = 1;

        // Randomized traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            rstn           = ($urandom_range(0, 199) != 0);
            t_valid        = ($urandom_range(0, 3) != 0);
            t_op           = $urandom_range(0, 1) != 0;
            t_cache_hit    = $urandom_range(0, 1) != 0;
            t_hit          = 4'b0001 << $urandom_range(0, 3);
            t_lru          = 4'b0001 << $urandom_range(0, 3);
            t_victim_dirty = $urandom_range(0, 1) != 0;
            t_r_rdy        = ($urandom_range(0, 2) == 0);
            t_r_valid      = ($urandom_range(0, 3) != 0);
            t_w_rdy        = ($urandom_range(0, 2) == 0);
            t_b_done       = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
